// File: rtl/note_sequencer_pkg.sv
// Shared types and the octave-0 note divider table
// for the note sequencer ahead of sound_driver.
package synth_pkg;

  localparam int DIV_W = 18;

  // clk / f for C3..B3 at a 10 MHz clk
  localparam logic [DIV_W-1:0] NOTE_TABLE [12] = '{
    18'd76445, 18'd72155, 18'd68105, 18'd64282,
    18'd60675, 18'd57269, 18'd54055, 18'd51021,
    18'd48158, 18'd45455, 18'd42903, 18'd40496
  };

  typedef enum logic [1:0] {
    SAW, SQUARE, TRI, SINE
  } mode_t;

  typedef enum logic [1:0] {
    IDLE, PLAY, RELEASE
  } seq_state_t;

  function automatic logic [DIV_W-1:0] note_div(
    input logic [3:0] idx
  );
    return (idx < 4'd12) ? NOTE_TABLE[idx] : '0;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Key/button inputs and sound_driver control outputs
// of the note sequencer.
interface note_sequencer_if #(
  parameter int NKEYS = 12
);
  import synth_pkg::*;

  logic [NKEYS-1:0] keys;
  logic             oct_up;
  logic             oct_down;
  logic             mode_btn;
  logic [DIV_W-1:0] divider;
  logic [1:0]       mode;
  logic             strobe;
  logic [3:0]       note_idx;

  modport master (
    output keys, oct_up, oct_down, mode_btn,
    input  divider, mode, strobe, note_idx
  );

  modport slave (
    input  keys, oct_up, oct_down, mode_btn,
    output divider, mode, strobe, note_idx
  );

endinterface

// File: rtl/note_sequencer_sync_edge.sv
// Two-flop synchronizer with rising-edge pulse; edges
// are suppressed until the pipeline holds real samples.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;
  logic [1:0]   prime;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1    <= '0;
      s2    <= '0;
      prev  <= '0;
      prime <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
      if (prime != 2'd3)
        prime <= prime + 2'd1;
    end
  end

  // inputs already high at reset release give no edge
  assign level = s2;
  assign rise  = (prime == 2'd3) ? (s2 & ~prev) : '0;

endmodule

// File: rtl/note_sequencer.sv
// Last-pressed key arbitration, octave shift, mode
// cycling and release hold in front of sound_driver.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int NKEYS          = 12,
  parameter int RELEASE_CYCLES = 100000,
  parameter int MAX_OCT        = 3
) (
  input logic clk,
  input logic nrst,
  note_sequencer_if.slave bus
);

  localparam int CW = (RELEASE_CYCLES > 0) ?
    $clog2(RELEASE_CYCLES + 1) : 1;
  localparam int OW = (MAX_OCT > 0) ?
    $clog2(MAX_OCT + 1) : 1;
  localparam logic [CW-1:0] RLOAD = CW'(
    (RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0);
  localparam logic [OW-1:0] OMAX = OW'(MAX_OCT);

  logic [NKEYS-1:0] key_lvl;
  logic [NKEYS-1:0] key_rise;
  logic             up_lvl, up_rise;
  logic             dn_lvl, dn_rise;
  logic             md_lvl, md_rise;

  sync_edge #(.W(NKEYS)) u_keys (
    .clk(clk), .nrst(nrst), .d(bus.keys),
    .level(key_lvl), .rise(key_rise)
  );
  sync_edge #(.W(1)) u_up (
    .clk(clk), .nrst(nrst), .d(bus.oct_up),
    .level(up_lvl), .rise(up_rise)
  );
  sync_edge #(.W(1)) u_dn (
    .clk(clk), .nrst(nrst), .d(bus.oct_down),
    .level(dn_lvl), .rise(dn_rise)
  );
  sync_edge #(.W(1)) u_md (
    .clk(clk), .nrst(nrst), .d(bus.mode_btn),
    .level(md_lvl), .rise(md_rise)
  );

  seq_state_t    state_q, state_d;
  logic [3:0]    note_q, note_d;
  logic [OW-1:0] oct_q, oct_d;
  mode_t         mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       rise_any;
  logic       held_any;
  logic [3:0] rise_idx;
  logic [3:0] held_idx;
  logic       cur_held;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      note_q  <= '0;
      oct_q   <= '0;
      mode_q  <= SAW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      oct_q   <= oct_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rise_any = |key_rise;
    held_any = |key_lvl;
    rise_idx = '0;
    held_idx = '0;
    cur_held = key_lvl[note_q];
    // descending scan so the lowest index is kept
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (key_rise[i]) rise_idx = 4'(i);
      if (key_lvl[i])  held_idx = 4'(i);
    end

    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rise_any) begin
          state_d = PLAY;
          note_d  = rise_idx;
        end
      end
      PLAY: begin
        if (rise_any) begin
          note_d = rise_idx;
        end else if (!held_any) begin
          if (RELEASE_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = RELEASE;
            cnt_d   = RLOAD;
          end
        end else if (!cur_held) begin
          note_d = held_idx;
        end
      end
      RELEASE: begin
        if (rise_any) begin
          state_d = PLAY;
          note_d  = rise_idx;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    oct_d = oct_q;
    if (up_rise && !dn_rise && oct_q != OMAX)
      oct_d = oct_q + 1'b1;
    else if (dn_rise && !up_rise && oct_q != '0)
      oct_d = oct_q - 1'b1;

    mode_d = mode_q;
    if (md_rise)
      mode_d = mode_t'(mode_q + 2'd1);
  end

  assign bus.strobe   = (state_q != IDLE);
  assign bus.divider  = (state_q == IDLE) ? '0 :
                        (note_div(note_q) >> oct_q);
  assign bus.mode     = mode_q;
  assign bus.note_idx = note_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed-vector bench for note_sequencer with a
// 10-cycle release phase.
module tb_note_sequencer;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  note_sequencer_if #(.NKEYS(12)) bus ();

  note_sequencer #(
    .NKEYS(12),
    .RELEASE_CYCLES(10),
    .MAX_OCT(3)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // counts cycles with strobe low over n ticks
  task automatic watch(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      if (bus.strobe !== 1'b1) lows++;
    end
  endtask

  task automatic pulse_oct(input logic u, input logic d);
    bus.oct_up   = u;
    bus.oct_down = d;
    tick(1);
    bus.oct_up   = 1'b0;
    bus.oct_down = 1'b0;
    tick(2);
  endtask

  task automatic pulse_mode();
    bus.mode_btn = 1'b1;
    tick(1);
    bus.mode_btn = 1'b0;
    tick(2);
  endtask

  int lows;
  int highs;

  localparam logic [1:0] MSEQ [5] =
    '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus.keys = '0;
    bus.oct_up = 1'b0;
    bus.oct_down = 1'b0;
    bus.mode_btn = 1'b0;
    tick(3);
    check("rst_strobe", 32'(bus.strobe), 0);
    check("rst_div", 32'(bus.divider), 0);
    check("rst_note", 32'(bus.note_idx), 0);
    check("rst_mode", 32'(bus.mode), 0);
    nrst = 1'b1;
    tick(5);

    // key 9, three-cycle latency
    bus.keys[9] = 1'b1;
    tick(2);
    check("lat_early", 32'(bus.strobe), 0);
    tick(1);
    check("k9_strobe", 32'(bus.strobe), 1);
    check("k9_note", 32'(bus.note_idx), 9);
    check("k9_div", 32'(bus.divider), 45455);

    bus.keys[11] = 1'b1;
    tick(3);
    check("k11_note", 32'(bus.note_idx), 11);
    check("k11_div", 32'(bus.divider), 40496);
    bus.keys[11] = 1'b0;
    watch(4, lows);
    check("fb_gap", 32'(lows), 0);
    check("fb_note", 32'(bus.note_idx), 9);
    check("fb_div", 32'(bus.divider), 45455);

    // simultaneous press from release phase
    bus.keys = '0;
    tick(3);
    bus.keys[0] = 1'b1;
    bus.keys[9] = 1'b1;
    tick(3);
    check("sim_strobe", 32'(bus.strobe), 1);
    check("sim_note", 32'(bus.note_idx), 0);
    check("sim_div", 32'(bus.divider), 76445);
    bus.keys[9] = 1'b0;

    pulse_oct(1'b1, 1'b0);
    check("oct_u1", 32'(bus.divider), 38222);
    pulse_oct(1'b1, 1'b1);
    check("oct_both", 32'(bus.divider), 38222);
    pulse_oct(1'b1, 1'b0);
    check("oct_u2", 32'(bus.divider), 19111);
    pulse_oct(1'b1, 1'b0);
    check("oct_u3", 32'(bus.divider), 9555);
    pulse_oct(1'b1, 1'b0);
    check("oct_sat_hi", 32'(bus.divider), 9555);
    pulse_oct(1'b0, 1'b1);
    check("oct_d1", 32'(bus.divider), 19111);
    pulse_oct(1'b0, 1'b1);
    check("oct_d2", 32'(bus.divider), 38222);
    pulse_oct(1'b0, 1'b1);
    check("oct_d3", 32'(bus.divider), 76445);
    pulse_oct(1'b0, 1'b1);
    check("oct_sat_lo", 32'(bus.divider), 76445);

    // 2 sync cycles + 10 release cycles high
    bus.keys = '0;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.strobe === 1'b1) highs++;
    end
    check("rel_len", 32'(highs), 12);
    check("rel_strobe", 32'(bus.strobe), 0);
    check("rel_div", 32'(bus.divider), 0);

    // press during release cycle 5
    bus.keys[0] = 1'b1;
    tick(3);
    bus.keys = '0;
    tick(7);
    bus.keys[4] = 1'b1;
    watch(10, lows);
    check("rel5_gap", 32'(lows), 0);
    check("rel5_note", 32'(bus.note_idx), 4);
    check("rel5_div", 32'(bus.divider), 60675);

    // key edge lands with the counter at 0
    bus.keys = '0;
    tick(10);
    bus.keys[2] = 1'b1;
    watch(6, lows);
    check("rel0_gap", 32'(lows), 0);
    check("rel0_note", 32'(bus.note_idx), 2);

    for (int i = 0; i < 5; i++) begin
      pulse_mode();
      check($sformatf("mode_%0d", i),
            32'(bus.mode), 32'(MSEQ[i]));
    end

    bus.keys = '0;
    tick(20);
    check("idle_strobe", 32'(bus.strobe), 0);
    check("idle_div", 32'(bus.divider), 0);
    check("idle_mode", 32'(bus.mode), 1);

    bus.keys[5] = 1'b1;
    tick(3);
    check("k5_div", 32'(bus.divider), 57269);
    nrst = 1'b0;
    tick(1);
    check("mid_rst_strobe", 32'(bus.strobe), 0);
    check("mid_rst_mode", 32'(bus.mode), 0);
    check("mid_rst_div", 32'(bus.divider), 0);

    // key held through reset release is not a press
    nrst = 1'b1;
    tick(10);
    check("held_rst", 32'(bus.strobe), 0);
    bus.keys = '0;
    tick(3);
    bus.keys[7] = 1'b1;
    tick(3);
    check("k7_strobe", 32'(bus.strobe), 1);
    check("k7_div", 32'(bus.divider), 51021);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
